// File: rtl/uart_txfifo.sv
// Byte FIFO feeding a UART transmitter through a txrdy / active-low write handshake.
// Latency: a push into an idle, empty FIFO shows write=0 in the third cycle (push, load, ISSUE).
// Backpressure: full drops pushes and sets sticky overflow; the transmitter paces pops via txrdy.
module uart_txfifo #(
    parameter int DEPTH       = 16,
    parameter int ACK_TIMEOUT = 32
) (
    input  logic                     mclkx16,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    input  logic                     clr_overflow,
    output logic                     busy,
    input  logic                     txrdy,
    output logic                     write,
    output logic [7:0]               tx_data
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int TW = $clog2(ACK_TIMEOUT) + 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_ACK = 2'd2,
        WAIT_RDY = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]   count_q, count_d;
    logic [TW-1:0]   tmr_q, tmr_d;
    logic [7:0]      tx_data_q;
    logic            write_q, busy_q, overflow_q;
    logic [7:0]      mem_q [DEPTH];
    logic            push, load;

    // Status is decoded straight from the registered count, so full is judged
    // before any pop happening in the same cycle.
    assign full     = (count_q == LW'(DEPTH));
    assign empty    = (count_q == '0);
    assign level    = count_q;
    assign overflow = overflow_q;
    assign busy     = busy_q;
    assign write    = write_q;
    assign tx_data  = tx_data_q;

    assign push = wr_en && !full;

    // Next-state logic for the transmit handshake; load marks the IDLE->ISSUE pop.
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty && txrdy) begin
                    load    = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT_ACK;
                tmr_d   = '0;
            end
            WAIT_ACK: begin
                if (!txrdy) begin
                    state_d = WAIT_RDY;
                    tmr_d   = '0;
                end else if (tmr_q == TW'(ACK_TIMEOUT - 1)) begin
                    // Transmitter never acknowledged; treat the byte as sent.
                    state_d = IDLE;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            WAIT_RDY: begin
                if (txrdy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Occupancy: simultaneous push and pop cancel out.
    always_comb begin
        count_d = count_q;
        case ({push, load})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage array has no reset; pointers and count define what is valid.
    always_ff @(posedge mclkx16) begin
        if (!reset && push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // Pointers, count, FSM and registered outputs.
    always_ff @(posedge mclkx16) begin
        if (reset) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            tmr_q      <= '0;
            tx_data_q  <= 8'h00;
            write_q    <= 1'b1;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            tmr_q    <= tmr_d;
            count_q  <= count_d;
            write_q  <= (state_d != ISSUE);
            busy_q   <= (state_d != IDLE);
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (load) begin
                rd_ptr_q  <= rd_ptr_q + 1'b1;
                tx_data_q <= mem_q[rd_ptr_q];
            end
            // A dropped push outranks a clear in the same cycle.
            if (wr_en && full) begin
                overflow_q <= 1'b1;
            end else if (clr_overflow) begin
                overflow_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_txfifo.sv
// Directed bench for uart_txfifo with a simple transmitter model and strobe monitor.
// Inputs change 1 time unit after the rising edge; outputs are checked at the same point.
// The transmitter model and monitor run on the falling edge.
module tb_uart_txfifo;

    logic        mclkx16 = 1'b0;
    logic        reset = 1'b1;
    logic        wr_en = 1'b0;
    logic [7:0]  wr_data = 8'h00;
    logic        clr_overflow = 1'b0;
    logic        man_txrdy = 1'b1;
    logic        model_txrdy = 1'b1;
    logic        uart_auto = 1'b0;
    logic        txrdy;
    logic        full, empty, overflow, busy, write;
    logic [4:0]  level;
    logic [7:0]  tx_data;

    int          vecs = 0;
    int          errs = 0;
    int          busy_len = 160;
    int          m_dly = 0;
    int          m_busy = 0;
    int          since_last = 1000;
    int          min_gap = 1000;
    int          long_strobes = 0;
    int          max_level = 0;
    int          n_before = 0;
    logic        prev_write = 1'b1;
    logic [7:0]  got [$];

    always #5 mclkx16 = ~mclkx16;

    assign txrdy = uart_auto ? model_txrdy : man_txrdy;

    uart_txfifo #(.DEPTH(16), .ACK_TIMEOUT(32)) dut (
        .mclkx16      (mclkx16),
        .reset        (reset),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .full         (full),
        .empty        (empty),
        .level        (level),
        .overflow     (overflow),
        .clr_overflow (clr_overflow),
        .busy         (busy),
        .txrdy        (txrdy),
        .write        (write),
        .tx_data      (tx_data)
    );

    // Transmitter model (drops txrdy 2 cycles after a strobe for busy_len cycles) and strobe monitor.
    always @(negedge mclkx16) begin
        if (!uart_auto) begin
            m_dly       = 0;
            m_busy      = 0;
            model_txrdy = 1'b1;
        end else begin
            if (m_dly != 0) begin
                m_dly = m_dly - 1;
                if (m_dly == 0) begin
                    model_txrdy = 1'b0;
                    m_busy      = busy_len;
                end
            end else if (m_busy != 0) begin
                m_busy = m_busy - 1;
                if (m_busy == 0) model_txrdy = 1'b1;
            end
            if (write === 1'b0) m_dly = 2;
        end
        since_last = since_last + 1;
        if (write === 1'b0) begin
            got.push_back(tx_data);
            if (prev_write === 1'b0) long_strobes = long_strobes + 1;
            if (since_last < min_gap) min_gap = since_last;
            since_last = 0;
        end
        prev_write = write;
        if (int'(level) > max_level) max_level = int'(level);
    end

    task automatic step();
        @(posedge mclkx16);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs = vecs + 1;
        assert (obs === exp) else begin
            errs = errs + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] got_at(input int i);
        if (i < got.size()) return 32'(got[i]);
        return 32'hFFFF_FFFF;
    endfunction

    initial begin
        // Reset with a push pending: reset must win.
        wr_en = 1'b1; wr_data = 8'hFF;
        step(); step();
        chk("rst_level",    32'(level),    32'd0);
        chk("rst_empty",    32'(empty),    32'd1);
        chk("rst_full",     32'(full),     32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_busy",     32'(busy),     32'd0);
        chk("rst_write",    32'(write),    32'd1);
        chk("rst_txdata",   32'(tx_data),  32'h00);
        wr_en = 1'b0; reset = 1'b0;
        step();

        // Single byte with a slow transmitter; latency push -> load -> ISSUE.
        got.delete();
        busy_len = 160; uart_auto = 1'b1;
        wr_en = 1'b1; wr_data = 8'hA5;
        step();
        wr_en = 1'b0;
        chk("one_level_after_push", 32'(level), 32'd1);
        chk("one_write_hi_load",    32'(write), 32'd1);
        step();
        chk("one_strobe",   32'(write),   32'd0);
        chk("one_txdata",   32'(tx_data), 32'hA5);
        chk("one_busy",     32'(busy),    32'd1);
        chk("one_empty",    32'(empty),   32'd1);
        step();
        chk("one_strobe_end", 32'(write), 32'd1);
        for (int k = 0; k < 400 && busy !== 1'b0; k++) step();
        chk("one_idle",        32'(busy),        32'd0);
        chk("one_txrdy_back",  32'(model_txrdy), 32'd1);
        chk("one_count",       32'(got.size()),  32'd1);
        chk("one_byte",        got_at(0),        32'hA5);
        chk("one_txdata_hold", 32'(tx_data),     32'hA5);

        // Fill past capacity with the transmitter stalled.
        uart_auto = 1'b0; man_txrdy = 1'b0;
        got.delete();
        for (int i = 0; i < 17; i++) begin
            wr_en = 1'b1; wr_data = 8'(i);
            step();
        end
        wr_en = 1'b0;
        chk("fill_full",     32'(full),     32'd1);
        chk("fill_level",    32'(level),    32'd16);
        chk("fill_overflow", 32'(overflow), 32'd1);
        chk("fill_busy",     32'(busy),     32'd0);

        // Clear racing an overflowing push, then a plain clear.
        clr_overflow = 1'b1; wr_en = 1'b1; wr_data = 8'hEE;
        step();
        chk("clr_vs_push_overflow", 32'(overflow), 32'd1);
        chk("clr_vs_push_level",    32'(level),    32'd16);
        wr_en = 1'b0;
        step();
        chk("clr_overflow", 32'(overflow), 32'd0);
        clr_overflow = 1'b0;

        // Drain with a toggling transmitter.
        busy_len = 3; uart_auto = 1'b1;
        for (int k = 0; k < 600 && !(empty === 1'b1 && busy === 1'b0); k++) step();
        chk("drain_idle",  32'(busy),       32'd0);
        chk("drain_count", 32'(got.size()), 32'd16);
        for (int i = 0; i < 16; i++) chk($sformatf("drain_byte%0d", i), got_at(i), 32'(i));

        // Interleaved push/drain, 40 bytes, pointers wrap twice.
        got.delete(); max_level = 0; busy_len = 2;
        for (int b = 0; b < 20; b++) begin
            wr_en = 1'b1; wr_data = 8'(8'h40 + 2 * b);
            step();
            wr_data = 8'(8'h41 + 2 * b);
            step();
            wr_en = 1'b0;
            repeat (8) step();
        end
        for (int k = 0; k < 600 && !(empty === 1'b1 && busy === 1'b0); k++) step();
        chk("wrap_count", 32'(got.size()), 32'd40);
        for (int i = 0; i < 40; i++) chk($sformatf("wrap_byte%0d", i), got_at(i), 32'(8'h40 + i));
        chk("wrap_max_level", 32'(max_level <= 16), 32'd1);
        chk("wrap_overflow",  32'(overflow),        32'd0);

        // Acknowledge timeout with txrdy stuck high.
        uart_auto = 1'b0; man_txrdy = 1'b1;
        reset = 1'b1; step(); reset = 1'b0;
        wr_en = 1'b1; wr_data = 8'h3C;
        step();
        wr_data = 8'h5A;
        step();
        wr_en = 1'b0;
        chk("to_strobe1", 32'(write),   32'd0);
        chk("to_data1",   32'(tx_data), 32'h3C);
        repeat (32) step();
        chk("to_last_wait_ack", 32'(busy),  32'd1);
        step();
        chk("to_idle",          32'(busy),  32'd0);
        chk("to_idle_write",    32'(write), 32'd1);
        step();
        chk("to_strobe2", 32'(write),   32'd0);
        chk("to_data2",   32'(tx_data), 32'h5A);
        repeat (40) step();

        // Reset while waiting for the transmitter with bytes still queued.
        reset = 1'b1; step(); reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h11 + i);
            if (i == 2) man_txrdy = 1'b0;
            step();
        end
        wr_en = 1'b0;
        chk("mid_busy",   32'(busy),    32'd1);
        chk("mid_level",  32'(level),   32'd4);
        chk("mid_txdata", 32'(tx_data), 32'h11);
        n_before = got.size();
        reset = 1'b1;
        step();
        chk("mid_rst_level",  32'(level),   32'd0);
        chk("mid_rst_write",  32'(write),   32'd1);
        chk("mid_rst_txdata", 32'(tx_data), 32'h00);
        chk("mid_rst_busy",   32'(busy),    32'd0);
        chk("mid_rst_empty",  32'(empty),   32'd1);
        reset = 1'b0; man_txrdy = 1'b1;
        repeat (20) step();
        chk("mid_no_strobes", 32'(got.size()), 32'(n_before));

        // Strobe shape across the whole run.
        chk("strobe_width",  32'(long_strobes), 32'd0);
        chk("strobe_min_gap", 32'(min_gap >= 4), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
